// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle.
//   btn_up_raw / btn_down_raw : raw, asynchronous, possibly bouncing button inputs
//   up / down                 : registered single-cycle count pulses
//   btn_level                 : debounced button levels {down, up}
// master: the side that owns the buttons and consumes the pulses.
// slave : the conditioner itself.
interface btn_conditioner_if;
  logic       btn_up_raw;
  logic       btn_down_raw;
  logic       up;
  logic       down;
  logic [1:0] btn_level;

  modport master (
    output btn_up_raw,
    output btn_down_raw,
    input  up,
    input  down,
    input  btn_level
  );

  modport slave (
    input  btn_up_raw,
    input  btn_down_raw,
    output up,
    output down,
    output btn_level
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner for the seconds counter.
// Each of the two buttons (index 0 = up, index 1 = down) is passed through a
// 2-flop synchroniser, a counting debouncer and a press/hold/auto-repeat FSM.
// The output stage turns FSM pulse requests into registered single-cycle
// up/down pulses, and drops both while both buttons are held.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : btn_conditioner_if.slave (raw buttons in, pulses and levels out)
// DEB_CYCLES must be >= 1; HOLD_CYCLES and REPEAT_CYCLES must be >= 1 and
// DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES must all be < 2**CW.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned REPEAT_CYCLES = 10,
  parameter int unsigned CW            = 8
) (
  input  logic              clk,
  input  logic              rst,
  btn_conditioner_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // The level flips on the clock where the mismatch count would reach
  // DEB_CYCLES, so the compare value is one less.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_LD   = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] TMR_ONE  = CW'(1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] req;
  logic       conflict;

  assign raw = {bus.btn_down_raw, bus.btn_up_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic          sync1;
    logic          sync2;
    logic          lvl_q;
    logic [CW-1:0] deb_cnt;
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [CW-1:0] tmr;
    logic [CW-1:0] tmr_n;
    logic          req_c;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw[ch];
        sync2 <= sync1;
      end
    end

    // Debouncer: any cycle of agreement restarts the count, so only a run of
    // DEB_CYCLES consecutive disagreeing samples moves the level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_q   <= 1'b0;
        deb_cnt <= '0;
      end else if (sync2 != lvl_q) begin
        if (deb_cnt == DEB_LAST) begin
          lvl_q   <= ~lvl_q;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    // Press / hold / auto-repeat. A low level is checked first so that a
    // release always wins over a timer expiring in the same cycle. The
    // request is combinational so the registered output lands one clock
    // after the debounced level rises.
    always_comb begin
      state_n = state;
      tmr_n   = tmr;
      req_c   = 1'b0;
      if (!lvl_q) begin
        state_n = ST_IDLE;
        tmr_n   = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            req_c   = 1'b1;
            tmr_n   = HOLD_LD;
            state_n = ST_HOLD;
          end
          ST_HOLD: begin
            if (tmr == TMR_ONE) begin
              req_c   = 1'b1;
              tmr_n   = REP_LD;
              state_n = ST_REPEAT;
            end else begin
              tmr_n = tmr - 1'b1;
            end
          end
          ST_REPEAT: begin
            if (tmr == TMR_ONE) begin
              req_c = 1'b1;
              tmr_n = REP_LD;
            end else begin
              tmr_n = tmr - 1'b1;
            end
          end
          default: begin
            state_n = ST_IDLE;
            tmr_n   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= ST_IDLE;
        tmr   <= '0;
      end else begin
        state <= state_n;
        tmr   <= tmr_n;
      end
    end

    assign lvl[ch] = lvl_q;
    assign req[ch] = req_c;
  end

  // Both FSMs keep running while both buttons are held; their requests are
  // simply discarded here rather than queued.
  assign conflict = lvl[0] & lvl[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.up   <= 1'b0;
      bus.down <= 1'b0;
    end else begin
      bus.up   <= req[0] & ~lvl[1] & ~conflict;
      bus.down <= req[1] & ~lvl[0] & ~conflict;
    end
  end

  // The debounced level registers are already flops; exported directly.
  assign bus.btn_level = lvl;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a pulse scoreboard: each expected
// pulse (channel and clock edge number) is queued when the stimulus is
// applied, and a negedge monitor pops and compares every observed pulse.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (50),
    .REPEAT_CYCLES(10),
    .CW           (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    bit          ch;
    int unsigned at;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input bit ch, input int unsigned at);
    exp_t e;
    e.ch = ch;
    e.at = at;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int unsigned e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Pulse monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (bus.up === 1'b1 || bus.down === 1'b1) begin
      chk("up_down_exclusive", {31'b0, bus.up & bus.down}, 32'd0);
      chk("no_pulse_in_reset", {31'b0, rst}, 32'd0);
      if (sbq.size() == 0) begin
        chk("pending_pulses", sbq.size(), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("pulse_is_down", {31'b0, bus.down}, {31'b0, e.ch});
        chk("pulse_edge", edge_n, e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    int unsigned k;

    rst = 1'b1;
    bus.btn_up_raw   = 1'b0;
    bus.btn_down_raw = 1'b0;
    step(2);
    chk("reset_up", {31'b0, bus.up}, 32'd0);
    chk("reset_down", {31'b0, bus.down}, 32'd0);
    chk("reset_level", {30'b0, bus.btn_level}, 32'd0);
    rst = 1'b0;
    step(3);

    // 1: clean press, 20 cycles
    e0 = edge_n + 1;
    bus.btn_up_raw = 1'b1;
    expect_pulse(1'b0, e0 + 6);
    wait_edge(e0 + 4);  chk("t1_level_e4", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(e0 + 5);  chk("t1_level_e5", {30'b0, bus.btn_level}, 32'd1);
    wait_edge(e0 + 19); bus.btn_up_raw = 1'b0;
    wait_edge(e0 + 24); chk("t1_level_e24", {30'b0, bus.btn_level}, 32'd1);
    wait_edge(e0 + 25); chk("t1_level_e25", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(e0 + 32); chk("t1_missing", sbq.size(), 32'd0);

    // 2: bounce (3 high / 1 low) x5, then steady
    for (int i = 0; i < 5; i++) begin
      bus.btn_up_raw = 1'b1;
      step(3);
      bus.btn_up_raw = 1'b0;
      step(1);
    end
    chk("t2_level_bounce", {30'b0, bus.btn_level}, 32'd0);
    k = edge_n + 1;
    bus.btn_up_raw = 1'b1;
    expect_pulse(1'b0, k + 6);
    wait_edge(k + 4);  chk("t2_level_k4", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(k + 5);  chk("t2_level_k5", {30'b0, bus.btn_level}, 32'd1);
    wait_edge(k + 10); bus.btn_up_raw = 1'b0;
    wait_edge(k + 22);
    chk("t2_level_rel", {30'b0, bus.btn_level}, 32'd0);
    chk("t2_missing", sbq.size(), 32'd0);

    // 3: down held edge 0..100, auto-repeat
    e0 = edge_n + 1;
    bus.btn_down_raw = 1'b1;
    expect_pulse(1'b1, e0 + 6);
    for (int unsigned r = 56; r <= 96; r += 10) expect_pulse(1'b1, e0 + r);
    wait_edge(e0 + 99);  bus.btn_down_raw = 1'b0;
    wait_edge(e0 + 115);
    chk("t3_level_rel", {30'b0, bus.btn_level}, 32'd0);
    chk("t3_missing", sbq.size(), 32'd0);

    // 4: both held, conflict suppresses everything
    e0 = edge_n + 1;
    bus.btn_up_raw   = 1'b1;
    bus.btn_down_raw = 1'b1;
    wait_edge(e0 + 4);  chk("t4_level_e4", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(e0 + 5);  chk("t4_level_e5", {30'b0, bus.btn_level}, 32'd3);
    wait_edge(e0 + 29);
    bus.btn_up_raw   = 1'b0;
    bus.btn_down_raw = 1'b0;
    wait_edge(e0 + 42);
    chk("t4_level_rel", {30'b0, bus.btn_level}, 32'd0);
    chk("t4_missing", sbq.size(), 32'd0);

    // 5: reset during hold/repeat, button still held afterwards
    e0 = edge_n + 1;
    bus.btn_up_raw = 1'b1;
    expect_pulse(1'b0, e0 + 6);
    expect_pulse(1'b0, e0 + 56);
    wait_edge(e0 + 60);
    rst = 1'b1;
    #1;
    chk("t5_rst_up", {31'b0, bus.up}, 32'd0);
    chk("t5_rst_level", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(e0 + 69);
    chk("t5_rst_level_late", {30'b0, bus.btn_level}, 32'd0);
    rst = 1'b0;
    expect_pulse(1'b0, e0 + 76);
    wait_edge(e0 + 74); chk("t5_level_e74", {30'b0, bus.btn_level}, 32'd0);
    wait_edge(e0 + 75); chk("t5_level_e75", {30'b0, bus.btn_level}, 32'd1);
    wait_edge(e0 + 80); bus.btn_up_raw = 1'b0;
    wait_edge(e0 + 95);
    chk("t5_missing", sbq.size(), 32'd0);

    // 6: 3-cycle glitch is ignored
    bus.btn_up_raw = 1'b1;
    step(3);
    bus.btn_up_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t6_level", {30'b0, bus.btn_level}, 32'd0);
      step(1);
    end
    chk("t6_missing", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the two raw push-button inputs (up, down) before the seconds counter.
- Synchronises, debounces and edge-detects each button, and adds hold-to-auto-repeat.
- Emits clean single-cycle up/down pulses that feed the counter's up/down inputs directly.
- Suppresses both pulses while both buttons are pressed.

Parameters:
DEB_CYCLES, 4, consecutive clocks a synchronised input must differ from its debounced level before the level flips
HOLD_CYCLES, 50, clocks from the first pulse to the first auto-repeat pulse
REPEAT_CYCLES, 10, clocks between subsequent auto-repeat pulses
CW, 8, width of each per-channel timer; DEB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must each be < 2^CW

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
btn_up_raw  input  1  raw up button, asynchronous, may bounce
btn_down_raw  input  1  raw down button, asynchronous, may bounce
up  output  1  single-cycle increment pulse, registered
down  output  1  single-cycle decrement pulse, registered
btn_level  output  2  debounced levels {down, up}, registered

Behaviour:
- Reset (async assert, sync release): synchronisers, debounced levels, timers = 0; FSMs = IDLE; up = down = 0; btn_level = 2'b00.
- Synchroniser: 2-flop per input.
- Debounce, per channel:
  - Counter increments each clock where the sync output differs from the debounced level.
  - Counter clears on any cycle where they match.
  - When the counter reaches DEB_CYCLES, the level flips and the counter clears.
  - Glitches shorter than DEB_CYCLES never change the level.
- FSM per channel, states IDLE, HOLD, REPEAT:
  - IDLE: debounced rising edge -> request pulse, load timer = HOLD_CYCLES, go to HOLD.
  - HOLD: decrement timer; at 1 with level high -> request pulse, load REPEAT_CYCLES, go to REPEAT.
  - REPEAT: decrement timer; at 1 with level high -> request pulse, reload REPEAT_CYCLES.
  - Level low in any state -> IDLE, timer = 0, no pulse. Release wins over timer expiry in the same cycle.
- Output stage: up = up request AND NOT down level AND NOT up level-conflict; down symmetric.
  - Whenever both debounced levels are high, both outputs are forced to 0.
  - Both FSMs keep running during a conflict. Suppressed pulses are dropped, not deferred.
- Latency: raw edge first sampled at edge 0 -> pulse high after edge DEB_CYCLES+2, for exactly one cycle.
- Pulse spacing:
  - First repeat comes HOLD_CYCLES edges after the first pulse.
  - Each later repeat comes REPEAT_CYCLES edges after the previous one.
  - Pulses are never wider than 1 cycle; up and down are never high together.
- Reset mid-operation:
  - Outputs drop to 0 immediately and all pending timing is lost.
  - A button still held at reset release is treated as a new press: pulse DEB_CYCLES+2 edges after the first post-reset edge.
- Release debounce uses the same DEB_CYCLES rule. The next press is only recognised after the level has returned low.

Test Plan:
1. Clean press (DEB=4): btn_up_raw high at edge 0 for 20 cycles -> one up pulse after edge 6; down stays 0; btn_level[0] high from edge 5 to edge 25.
2. Bounce: btn_up_raw toggles 3 high / 1 low five times, then steady high from edge k -> no pulse during bounce; exactly one up pulse after edge k+6.
3. Auto-repeat (HOLD=50, REPEAT=10): btn_down_raw held from edge 0 to edge 100 -> down pulses after edges 6, 56, 66, 76, 86, 96 (6 total); no pulse at 106.
4. Conflict: both raw inputs high from edge 0 for 30 cycles -> up = down = 0 throughout; btn_level = 2'b11 from edge 5.
5. Reset mid-hold: btn_up_raw held, rst asserted between edges 60 and 70 -> up = 0 immediately and through reset; first up pulse after edge 76 (first post-reset edge 70).
6. Short glitch: btn_up_raw high for 3 cycles only -> btn_level stays 0; no pulse.
